// File: rtl/ecc_scrub_pkg.sv
// Shared definitions for the ECC scrubber slice.
//   DATA_W / ECC_W : SECDED word geometry (64 data + 8 check bits)
//   CNT_W          : width of the SBE/DBE event counters
//   state_e        : scrubber FSM state encoding
package ecc_scrub_pkg;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ECC_W  = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE, GAP, RD, CHK, DEC, ENC, WR, NEXT
  } state_e;
endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating incrementer: counts inc_i pulses and holds at all-ones.
//   clk, rstn : clock, async active-low reset
//   inc_i     : increment request (one count per cycle)
//   cnt_o     : current count
module ecc_sat_cnt
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber for a 64b+8b SECDED SRAM. Walks addresses 0..DEPTH-1,
// reads each word, hands it to an external decoder and, on a single-bit
// error, re-encodes the corrected word via the shared registered encoder and
// writes it back. The host always owns the SRAM port when host_busy is high.
// Ports:
//   clk, rstn            clock, async active-low reset
//   scrub_en, interval   enable level, idle cycles before each scrub read
//   host_busy/we/addr    host activity on the shared SRAM port
//   mem_*                scrubber SRAM request, address, writeback, read data
//   dec_*                decoder input (captured read word) and results
//   enc_*                shared encoder input and registered outputs
//   sbe_cnt, dbe_cnt     saturating error counters
//   dbe_addr, pass_done  last DBE address, pulse on DEPTH-1 -> 0 wrap
// Build option ECC_SCRUB_IRQ_EN adds irq (sticky on DBE) and irq_clr.
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  scrub_en,
  input  logic [INTERVAL_W-1:0] interval,
  input  logic                  host_busy,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [ECC_W-1:0]      mem_wecc,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic [ECC_W-1:0]      mem_recc,
  output logic [DATA_W-1:0]     dec_data,
  output logic [ECC_W-1:0]      dec_ecc,
  input  logic                  dec_sbe,
  input  logic                  dec_dbe,
  input  logic [DATA_W-1:0]     dec_corr,
  output logic [DATA_W-1:0]     enc_din,
  input  logic [DATA_W-1:0]     enc_dout,
  input  logic [ECC_W-1:0]      enc_ecc,
  output logic [CNT_W-1:0]      sbe_cnt,
  output logic [CNT_W-1:0]      dbe_cnt,
  output logic [ADDR_W-1:0]     dbe_addr,
  output logic                  pass_done
`ifdef ECC_SCRUB_IRQ_EN
  ,
  output logic                  irq,
  input  logic                  irq_clr
`endif
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e                  state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [INTERVAL_W-1:0]   gap_q;
  logic [DATA_W-1:0]       dec_data_q, enc_din_q, wdata_q;
  logic [ECC_W-1:0]        dec_ecc_q, wecc_q;
  logic [ADDR_W-1:0]       dbe_addr_q;
  logic                    pass_done_q;
  logic                    cancel_q;
  logic                    enc_wait_q;

  logic host_hit, sbe_inc, dbe_inc;

  // A host write to the word being scrubbed makes the pending writeback stale.
  assign host_hit = host_busy && host_we && (host_addr == addr_q);

  assign mem_req = ((state_q == RD) || (state_q == WR)) && !host_busy;
  assign mem_we  = (state_q == WR) && !host_busy;

  // DBE dominates: a word flagged both ways counts only as a DBE.
  assign dbe_inc = (state_q == DEC) && dec_dbe;
  assign sbe_inc = (state_q == DEC) && dec_sbe && !dec_dbe;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      gap_q       <= '0;
      dec_data_q  <= '0;
      dec_ecc_q   <= '0;
      enc_din_q   <= '0;
      wdata_q     <= '0;
      wecc_q      <= '0;
      dbe_addr_q  <= '0;
      pass_done_q <= 1'b0;
      cancel_q    <= 1'b0;
      enc_wait_q  <= 1'b0;
    end else begin
      pass_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (scrub_en) begin
            if (interval == '0) state_q <= RD;
            else begin
              gap_q   <= interval;
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (!scrub_en) begin
            gap_q   <= '0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
            if (gap_q == INTERVAL_W'(1)) state_q <= RD;
          end
        end
        RD: begin
          if (!host_busy) state_q <= CHK;
        end
        CHK: begin
          dec_data_q <= mem_rdata;
          dec_ecc_q  <= mem_recc;
          cancel_q   <= host_hit;
          state_q    <= DEC;
        end
        DEC: begin
          cancel_q <= 1'b0;
          if (dec_dbe) begin
            dbe_addr_q <= addr_q;
            state_q    <= NEXT;
          end else if (dec_sbe && !(cancel_q || host_hit)) begin
            enc_din_q  <= dec_corr;
            enc_wait_q <= 1'b0;
            state_q    <= ENC;
          end else begin
            state_q <= NEXT;
          end
        end
        ENC: begin
          // First cycle presents enc_din; encoder output is valid on the second.
          if (host_hit) begin
            enc_wait_q <= 1'b0;
            state_q    <= NEXT;
          end else if (!enc_wait_q) begin
            enc_wait_q <= 1'b1;
          end else begin
            wdata_q    <= enc_dout;
            wecc_q     <= enc_ecc;
            enc_wait_q <= 1'b0;
            state_q    <= WR;
          end
        end
        WR: begin
          // host_hit implies host_busy, so no write issues on a cancel.
          if (host_hit || !host_busy) state_q <= NEXT;
        end
        NEXT: begin
          if (addr_q == LAST_ADDR) begin
            addr_q      <= '0;
            pass_done_q <= 1'b1;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
          if (!scrub_en) state_q <= IDLE;
          else if (interval == '0) state_q <= RD;
          else begin
            gap_q   <= interval;
            state_q <= GAP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ecc_sat_cnt #(.W(CNT_W)) u_sbe_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (sbe_inc),
    .cnt_o (sbe_cnt)
  );

  ecc_sat_cnt #(.W(CNT_W)) u_dbe_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (dbe_inc),
    .cnt_o (dbe_cnt)
  );

`ifdef ECC_SCRUB_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        irq_q <= 1'b0;
    else if (dbe_inc) irq_q <= 1'b1;
    else if (irq_clr) irq_q <= 1'b0;
  end
  assign irq = irq_q;
`endif

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wecc  = wecc_q;
  assign dec_data  = dec_data_q;
  assign dec_ecc   = dec_ecc_q;
  assign enc_din   = enc_din_q;
  assign dbe_addr  = dbe_addr_q;
  assign pass_done = pass_done_q;
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
module tb_ecc_scrub_ctrl;
  localparam int unsigned AW = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        scrub_en = 1'b0;
  logic [7:0]  interval = '0;
  logic        host_busy = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic        mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wecc;
  logic [63:0] mem_rdata = '0;
  logic [7:0]  mem_recc = '0;
  logic [63:0] dec_data, dec_corr, enc_din;
  logic [7:0]  dec_ecc;
  logic        dec_sbe, dec_dbe;
  logic [63:0] enc_dout = '0;
  logic [7:0]  enc_ecc = '0;
  logic [15:0] sbe_cnt, dbe_cnt;
  logic [AW-1:0] dbe_addr;
  logic        pass_done;
`ifdef ECC_SCRUB_IRQ_EN
  logic        irq;
  logic        irq_clr = 1'b0;
`endif

  logic        sat_inc = 1'b0;
  logic [3:0]  sat_cnt;

  int vectors = 0, miscompares = 0;
  int rd_cnt = 0, wr_cnt = 0, pass_cnt = 0, viol = 0, cyc = 0;
  int last_rd_cyc = 0, prev_rd_cyc = 0;
  logic [AW-1:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [63:0] last_wdata = '0;
  logic [7:0]  last_wecc = '0;
  logic        both_mode = 1'b0;

  logic [63:0] gold [16];
  logic [63:0] mem  [16];
  logic [7:0]  mem_e[16];

  always #5 clk = ~clk;

  function automatic logic [7:0] toy_ecc(input logic [63:0] d);
    return d[7:0] ^ d[63:56] ^ 8'h5A;
  endfunction

  // Decoder stand-in: compare captured word with the known-good contents.
  logic [63:0] diff;
  assign diff     = dec_data ^ gold[last_rd_addr];
  assign dec_dbe  = ($countones(diff) >= 2);
  assign dec_sbe  = ($countones(diff) == 1) || (both_mode && ($countones(diff) >= 2));
  assign dec_corr = gold[last_rd_addr];

  ecc_scrub_ctrl #(.ADDR_W(AW), .DEPTH(8), .INTERVAL_W(8)) dut (
    .clk(clk), .rstn(rstn), .scrub_en(scrub_en), .interval(interval),
    .host_busy(host_busy), .host_we(host_we), .host_addr(host_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wecc(mem_wecc),
    .mem_rdata(mem_rdata), .mem_recc(mem_recc),
    .dec_data(dec_data), .dec_ecc(dec_ecc), .dec_sbe(dec_sbe), .dec_dbe(dec_dbe),
    .dec_corr(dec_corr), .enc_din(enc_din), .enc_dout(enc_dout), .enc_ecc(enc_ecc),
    .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .dbe_addr(dbe_addr), .pass_done(pass_done)
`ifdef ECC_SCRUB_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

  ecc_sat_cnt #(.W(4)) u_sat (.clk(clk), .rstn(rstn), .inc_i(sat_inc), .cnt_o(sat_cnt));

  // SRAM, encoder and transaction monitor.
  always @(posedge clk) begin
    cyc++;
    if (mem_req && host_busy) viol++;
    if (mem_req && !host_busy) begin
      if (mem_we) begin
        wr_cnt++;
        last_wr_addr = mem_addr;
        last_wdata   = mem_wdata;
        last_wecc    = mem_wecc;
        mem[mem_addr]   = mem_wdata;
        mem_e[mem_addr] = mem_wecc;
      end else begin
        rd_cnt++;
        last_rd_addr = mem_addr;
        prev_rd_cyc  = last_rd_cyc;
        last_rd_cyc  = cyc;
        mem_rdata <= mem[mem_addr];
        mem_recc  <= mem_e[mem_addr];
      end
    end
    if (host_busy && host_we) begin
      mem[host_addr]   = gold[host_addr];
      mem_e[host_addr] = toy_ecc(gold[host_addr]);
    end
    if (pass_done) pass_cnt++;
    enc_dout <= enc_din;
    enc_ecc  <= toy_ecc(enc_din);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int n, r0, w0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      gold[i]  = 64'h0123_4567_89AB_CD00 | 64'(i);
      mem[i]   = gold[i];
      mem_e[i] = toy_ecc(gold[i]);
    end
    cycles(3);
    // Reset state
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wecc", 64'(mem_wecc), 0);
    chk("rst_dec_data", dec_data, 0);
    chk("rst_enc_din", enc_din, 0);
    chk("rst_sbe_cnt", 64'(sbe_cnt), 0);
    chk("rst_dbe_cnt", 64'(dbe_cnt), 0);
    chk("rst_dbe_addr", 64'(dbe_addr), 0);
    chk("rst_pass_done", 64'(pass_done), 0);
`ifdef ECC_SCRUB_IRQ_EN
    chk("rst_irq", 64'(irq), 0);
`endif
    rstn = 1'b1;
    cycles(2);

    // Clean pass, interval 0
    scrub_en = 1'b1;
    n = 0;
    while (pass_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("t1_pass_seen", 64'(pass_done), 1);
    chk("t1_reads", 64'(rd_cnt), 8);
    chk("t1_writes", 64'(wr_cnt), 0);
    chk("t1_rd_period", 64'(last_rd_cyc - prev_rd_cyc), 4);
    scrub_en = 1'b0;
    cycles(8);
    chk("t1_reads_after_stop", 64'(rd_cnt), 9);
    chk("t1_addr_retained", 64'(mem_addr), 1);
    chk("t1_pass_cnt", 64'(pass_cnt), 1);
    chk("t1_sbe", 64'(sbe_cnt), 0);
    chk("t1_dbe", 64'(dbe_cnt), 0);
    chk("t1_dec_data", dec_data, gold[0]);
    chk("t1_dec_ecc", 64'(dec_ecc), 64'(toy_ecc(gold[0])));

    // SBE at 3 (bit 17), DBE at 5 with sbe also flagged
    mem[3] = gold[3] ^ (64'd1 << 17);
    mem[5] = gold[5] ^ 64'h6;
    both_mode = 1'b1;
    scrub_en = 1'b1;
    n = 0;
    while (pass_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("t2_pass_seen", 64'(pass_done), 1);
    scrub_en = 1'b0;
    cycles(10);
    chk("t2_writes", 64'(wr_cnt), 1);
    chk("t2_wr_addr", 64'(last_wr_addr), 3);
    chk("t2_wdata", last_wdata, gold[3]);
    chk("t2_wecc", 64'(last_wecc), 64'(toy_ecc(gold[3])));
    chk("t2_sbe", 64'(sbe_cnt), 1);
    chk("t3_dbe", 64'(dbe_cnt), 1);
    chk("t3_dbe_addr", 64'(dbe_addr), 5);
    chk("t2_addr", 64'(mem_addr), 1);
    chk("t2_pass_cnt", 64'(pass_cnt), 2);
`ifdef ECC_SCRUB_IRQ_EN
    chk("t3_irq_set", 64'(irq), 1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("t3_irq_clr", 64'(irq), 0);
`endif
    mem[5] = gold[5];
    mem_e[5] = toy_ecc(gold[5]);
    both_mode = 1'b0;

    // Host busy stalls both read and write of an SBE at addr 1
    mem[1] = gold[1] ^ (64'd1 << 17);
    @(negedge clk);
    scrub_en = 1'b1;
    host_busy = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_rd_stall", 64'(mem_req), 0);
    end
    host_busy = 1'b0;
    r0 = rd_cnt;
    #1;
    chk("t4_rd_free_req", 64'({mem_req, mem_we}), 64'b10);
    @(negedge clk);
    chk("t4_rd_issued", 64'(rd_cnt), 64'(r0 + 1));
    chk("t4_rd_addr", 64'(last_rd_addr), 1);
    host_busy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t4_wr_stall", 64'(mem_req), 0);
    end
    host_busy = 1'b0;
    w0 = wr_cnt;
    #1;
    chk("t4_wr_free_req", 64'({mem_req, mem_we}), 64'b11);
    @(negedge clk);
    chk("t4_wr_issued", 64'(wr_cnt), 64'(w0 + 1));
    chk("t4_wr_addr", 64'(last_wr_addr), 1);
    chk("t4_wdata", last_wdata, gold[1]);
    chk("t4_sbe", 64'(sbe_cnt), 2);
    scrub_en = 1'b0;
    cycles(4);
    chk("t4_addr", 64'(mem_addr), 2);
    chk("t4_no_more_rd", 64'(rd_cnt), 64'(r0 + 1));

    // Host write to addr 3 while its SBE writeback is being encoded
    mem[3] = gold[3] ^ (64'd1 << 17);
    r0 = rd_cnt;
    w0 = wr_cnt;
    scrub_en = 1'b1;
    n = 0;
    while (!(rd_cnt == r0 + 2 && last_rd_addr == 3) && n < 50) begin @(negedge clk); n++; end
    chk("t5_rd3_seen", 64'(last_rd_addr), 3);
    cycles(2);
    host_busy = 1'b1;
    host_we   = 1'b1;
    host_addr = 4'd3;
    scrub_en  = 1'b0;
    @(negedge clk);
    host_busy = 1'b0;
    host_we   = 1'b0;
    cycles(6);
    chk("t5_no_write", 64'(wr_cnt), 64'(w0));
    chk("t5_sbe", 64'(sbe_cnt), 3);
    chk("t5_addr", 64'(mem_addr), 4);
    chk("t5_reads", 64'(rd_cnt), 64'(r0 + 2));

    // Interval 5: read-to-read spacing grows by exactly 5 idle cycles
    interval = 8'd5;
    r0 = rd_cnt;
    scrub_en = 1'b1;
    n = 0;
    while (rd_cnt < r0 + 3 && n < 100) begin @(negedge clk); n++; end
    chk("t6_reads", 64'(rd_cnt), 64'(r0 + 3));
    chk("t6_rd_period", 64'(last_rd_cyc - prev_rd_cyc), 9);
    chk("t6_no_write", 64'(wr_cnt), 64'(w0));

    // Async reset mid-operation
    #2;
    rstn = 1'b0;
    #1;
    chk("t7_req", 64'(mem_req), 0);
    chk("t7_addr", 64'(mem_addr), 0);
    chk("t7_sbe", 64'(sbe_cnt), 0);
    chk("t7_dbe_addr", 64'(dbe_addr), 0);
    scrub_en = 1'b0;
    interval = '0;
    cycles(2);
    rstn = 1'b1;
    cycles(3);
    chk("t7_no_write", 64'(wr_cnt), 64'(w0));
    chk("t7_idle_req", 64'(mem_req), 0);

    // Saturating counter boundary
    sat_inc = 1'b1;
    cycles(14);
    chk("t8_sat_14", 64'(sat_cnt), 14);
    cycles(1);
    chk("t8_sat_max", 64'(sat_cnt), 15);
    cycles(5);
    chk("t8_sat_hold", 64'(sat_cnt), 15);
    sat_inc = 1'b0;

    chk("host_busy_req_viol", 64'(viol), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
